// File: rtl/sha256_rounds.sv
// SHA-256 compression: 64 rounds at one round per clock, then the chaining-value add.
// Start on en, one-cycle done pulse with the digest on H_out; busy spans the block.
module sha256_rounds #(
    parameter int unsigned WORD_S = 32,
    parameter int unsigned ROUNDS = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [ROUNDS*WORD_S-1:0]   W,
    input  logic [8*WORD_S-1:0]        H_in,
    output logic [8*WORD_S-1:0]        H_out,
    output logic                       done,
    output logic                       busy
);

    localparam int unsigned RW = $clog2(ROUNDS);
    localparam logic [RW-1:0] RND_LAST = RW'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t state, state_nx;

    logic [RW-1:0]              rnd;
    logic [ROUNDS*WORD_S-1:0]   w_lat;
    logic [8*WORD_S-1:0]        h_lat;
    logic [WORD_S-1:0]          a, b, c, d, e, f, g, h;
    logic [WORD_S-1:0]          k_word, w_word, t1, t2;

    function automatic logic [WORD_S-1:0] ror(input logic [WORD_S-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_S - n));
    endfunction

    // Word i of a packed 8-word vector, H0 in the MSBs.
    function automatic logic [WORD_S-1:0] hword(input logic [8*WORD_S-1:0] v, input int unsigned i);
        return v[(7 - i)*WORD_S +: WORD_S];
    endfunction

    always_comb begin
        k_word = '0;
        case (rnd)
            6'd0:  k_word = 32'h428a2f98;  6'd1:  k_word = 32'h71374491;  6'd2:  k_word = 32'hb5c0fbcf;  6'd3:  k_word = 32'he9b5dba5;
            6'd4:  k_word = 32'h3956c25b;  6'd5:  k_word = 32'h59f111f1;  6'd6:  k_word = 32'h923f82a4;  6'd7:  k_word = 32'hab1c5ed5;
            6'd8:  k_word = 32'hd807aa98;  6'd9:  k_word = 32'h12835b01;  6'd10: k_word = 32'h243185be;  6'd11: k_word = 32'h550c7dc3;
            6'd12: k_word = 32'h72be5d74;  6'd13: k_word = 32'h80deb1fe;  6'd14: k_word = 32'h9bdc06a7;  6'd15: k_word = 32'hc19bf174;
            6'd16: k_word = 32'he49b69c1;  6'd17: k_word = 32'hefbe4786;  6'd18: k_word = 32'h0fc19dc6;  6'd19: k_word = 32'h240ca1cc;
            6'd20: k_word = 32'h2de92c6f;  6'd21: k_word = 32'h4a7484aa;  6'd22: k_word = 32'h5cb0a9dc;  6'd23: k_word = 32'h76f988da;
            6'd24: k_word = 32'h983e5152;  6'd25: k_word = 32'ha831c66d;  6'd26: k_word = 32'hb00327c8;  6'd27: k_word = 32'hbf597fc7;
            6'd28: k_word = 32'hc6e00bf3;  6'd29: k_word = 32'hd5a79147;  6'd30: k_word = 32'h06ca6351;  6'd31: k_word = 32'h14292967;
            6'd32: k_word = 32'h27b70a85;  6'd33: k_word = 32'h2e1b2138;  6'd34: k_word = 32'h4d2c6dfc;  6'd35: k_word = 32'h53380d13;
            6'd36: k_word = 32'h650a7354;  6'd37: k_word = 32'h766a0abb;  6'd38: k_word = 32'h81c2c92e;  6'd39: k_word = 32'h92722c85;
            6'd40: k_word = 32'ha2bfe8a1;  6'd41: k_word = 32'ha81a664b;  6'd42: k_word = 32'hc24b8b70;  6'd43: k_word = 32'hc76c51a3;
            6'd44: k_word = 32'hd192e819;  6'd45: k_word = 32'hd6990624;  6'd46: k_word = 32'hf40e3585;  6'd47: k_word = 32'h106aa070;
            6'd48: k_word = 32'h19a4c116;  6'd49: k_word = 32'h1e376c08;  6'd50: k_word = 32'h2748774c;  6'd51: k_word = 32'h34b0bcb5;
            6'd52: k_word = 32'h391c0cb3;  6'd53: k_word = 32'h4ed8aa4a;  6'd54: k_word = 32'h5b9cca4f;  6'd55: k_word = 32'h682e6ff3;
            6'd56: k_word = 32'h748f82ee;  6'd57: k_word = 32'h78a5636f;  6'd58: k_word = 32'h84c87814;  6'd59: k_word = 32'h8cc70208;
            6'd60: k_word = 32'h90befffa;  6'd61: k_word = 32'ha4506ceb;  6'd62: k_word = 32'hbef9a3f7;  6'd63: k_word = 32'hc67178f2;
            default: k_word = '0;
        endcase
    end

    always_comb begin
        w_word = w_lat[rnd*WORD_S +: WORD_S];
        t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k_word + w_word;
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = ROUND;
            ROUND:   if (rnd == RND_LAST) state_nx = FINAL;
            FINAL:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rnd   <= '0;
            w_lat <= '0;
            h_lat <= '0;
            {a, b, c, d, e, f, g, h} <= '0;
            H_out <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        w_lat <= W;
                        h_lat <= H_in;
                        {a, b, c, d, e, f, g, h} <= H_in;
                        rnd   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ROUND: begin
                    h   <= g;
                    g   <= f;
                    f   <= e;
                    e   <= d + t1;
                    d   <= c;
                    c   <= b;
                    b   <= a;
                    a   <= t1 + t2;
                    rnd <= rnd + 1'b1;
                end
                FINAL: begin
                    H_out <= {hword(h_lat, 0) + a, hword(h_lat, 1) + b,
                              hword(h_lat, 2) + c, hword(h_lat, 3) + d,
                              hword(h_lat, 4) + e, hword(h_lat, 5) + f,
                              hword(h_lat, 6) + g, hword(h_lat, 7) + h};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_rounds.sv
// Scoreboard bench for sha256_rounds: known-answer digests, latency, chaining, en-while-busy and async reset.
module tb_sha256_rounds;

    logic          clk;
    logic          reset;
    logic          en;
    logic [2047:0] W;
    logic [255:0]  H_in;
    logic [255:0]  H_out;
    logic          done;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [255:0] digest;
        bit           chk;
        int           due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_CHAIN = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [511:0] B_ABC   = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_CQ1   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_CQ2   = {448'h0, 32'h00000000, 32'h000001c0};

    sha256_rounds #(.WORD_S(32), .ROUNDS(64)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .W     (W),
        .H_in  (H_in),
        .H_out (H_out),
        .done  (done),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message schedule expansion of a 512-bit block (first word in the MSBs).
    function automatic logic [2047:0] sched(input logic [511:0] blk);
        logic [31:0]   w [64];
        logic [2047:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 64; i++) r[i*32 +: 32] = w[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [511:0] blk, input logic [255:0] hin, input logic [255:0] dig, input bit chk);
        exp_t x;
        en   = 1'b1;
        W    = sched(blk);
        H_in = hin;
        x.digest = dig;
        x.chk    = chk;
        x.due    = cyc + 66;
        q.push_back(x);
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 100; k++) begin
            if (done === 1'b1) return;
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: no done within 100 cycles, required done", name);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                mon_e = q.pop_front();
                if (cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL done_latency: done at cycle %0d, required cycle %0d", cyc, mon_e.due);
                end
                if (mon_e.chk) begin
                    checks++;
                    if (H_out !== mon_e.digest) begin
                        errors++;
                        $display("FAIL digest: got %h, required %h", H_out, mon_e.digest);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_bad;
        reset = 1'b0;
        en    = 1'b0;
        W     = '0;
        H_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_H_out", H_out, '0);
        check("reset_done", {255'h0, done}, '0);
        check("reset_busy", {255'h0, busy}, '0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        issue(B_ABC, IV, D_ABC, 1'b1);
        check("busy_after_accept", {255'h0, busy}, 256'h1);
        wait_done("abc");
        check("busy_at_done", {255'h0, busy}, '0);
        @(posedge clk); #1;
        check("done_one_cycle", {255'h0, done}, '0);
        check("H_out_holds", H_out, D_ABC);

        issue(B_EMPTY, IV, D_EMPTY, 1'b1);
        wait_done("empty");
        @(posedge clk); #1;

        // Block 2 starts in the very cycle block 1 reports done.
        issue(B_CQ1, IV, '0, 1'b0);
        wait_done("chain1");
        issue(B_CQ2, H_out, D_CHAIN, 1'b1);
        check("busy_back_to_back", {255'h0, busy}, 256'h1);
        wait_done("chain2");
        @(posedge clk); #1;

        issue(B_ABC, IV, D_ABC, 1'b1);
        busy_bad = 0;
        for (int k = 1; k <= 64; k++) begin
            if (k == 10 || k == 40) begin
                en   = 1'b1;
                W    = sched(B_EMPTY) ^ {64{$urandom()}};
                H_in = {8{$urandom()}};
            end else begin
                en = 1'b0;
            end
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk); #1;
        end
        en = 1'b0;
        check("busy_held_while_en_ignored", busy_bad, '0);
        wait_done("ignore_en");
        @(posedge clk); #1;

        issue(B_EMPTY, IV, D_EMPTY, 1'b1);
        repeat (29) @(posedge clk);
        #3;
        reset = 1'b0;
        q.delete();
        #1;
        check("async_reset_H_out", H_out, '0);
        check("async_reset_done", {255'h0, done}, '0);
        check("async_reset_busy", {255'h0, busy}, '0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (70) @(posedge clk);
        #1;
        check("idle_after_abort_busy", {255'h0, busy}, '0);
        issue(B_ABC, IV, D_ABC, 1'b1);
        wait_done("after_reset");
        @(posedge clk); #1;

        issue(B_ABC, IV, D_ABC, 1'b1);
        W    = '1;
        H_in = '1;
        wait_done("inputs_changed");
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected results outstanding, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
